// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (IF) and load/store (MEM); MEM wins ties.
// Access takes >=3 cycles (IDLE->BUSY->DONE); ARB_PERF_CNT_EN adds saturating stall/conflict counters.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          arb_err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_if_stall,
    output logic [31:0]   perf_mem_stall,
    output logic [31:0]   perf_conflict
`endif
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_drop;
    logic            r_if_done;
    logic            r_d_done;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_arb_err;
    logic            w_if_ready;
    logic            w_d_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_drop      <= 1'b0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_arb_err   <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_drop <= 1'b0;
                    if (d_req) begin
                        r_state     <= BUSY_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                    end else if (if_req && !if_flush) begin
                        r_state    <= BUSY_I;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= if_addr;
                    end
                end
                BUSY_D, BUSY_I: begin
                    if (r_state == BUSY_I && if_flush)
                        r_drop <= 1'b1;
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_state == BUSY_D) begin
                            r_d_rdata <= mem_rdata;
                            r_d_done  <= 1'b1;
                            r_state   <= DONE_D;
                        end else begin
                            r_if_rdata <= mem_rdata;
                            // a flush seen in the final BUSY cycle also kills the pulse
                            r_if_done  <= !(r_drop || if_flush);
                            r_state    <= DONE_I;
                        end
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_arb_err <= 1'b1;
                        r_drop    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE_D, DONE_I: begin
                    r_drop  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_if_ready = r_if_done & ~if_flush;
    assign w_d_ready  = r_d_done;

    assign if_ready  = w_if_ready;
    assign d_ready   = w_d_ready;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall_if  = if_req & ~w_if_ready;
    assign stall_mem = d_req & ~w_d_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign arb_err   = r_arb_err;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_mem;
    logic [31:0] r_perf_cfl;
    logic        w_conflict;

    assign w_conflict = (r_state == IDLE) & d_req & if_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_if  <= '0;
            r_perf_mem <= '0;
            r_perf_cfl <= '0;
        end else begin
            if (stall_if && r_perf_if != 32'hFFFF_FFFF)
                r_perf_if <= r_perf_if + 32'd1;
            if (stall_mem && r_perf_mem != 32'hFFFF_FFFF)
                r_perf_mem <= r_perf_mem + 32'd1;
            if (w_conflict && r_perf_cfl != 32'hFFFF_FFFF)
                r_perf_cfl <= r_perf_cfl + 32'd1;
        end
    end

    assign perf_if_stall  = r_perf_if;
    assign perf_mem_stall = r_perf_mem;
    assign perf_conflict  = r_perf_cfl;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a wait-state memory responder (TIMEOUT=4).
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        arb_err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_mem_stall;
    logic [31:0] perf_conflict;
`endif

    int          n_vec;
    int          n_err;
    int          waits;
    int          wcnt;
    logic [31:0] rd_val;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .arb_err(arb_err)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_stall(perf_if_stall),
        .perf_mem_stall(perf_mem_stall),
        .perf_conflict(perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = rd_val;

    // memory answers on the (waits+1)-th cycle of each strobe
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ready = (wcnt == waits);
            wcnt      = wcnt + 1;
        end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    initial begin
        n_vec = 0; n_err = 0; waits = 0; wcnt = 0; mem_ready = 1'b0;
        rd_val = 32'h0; reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

        // reset state
        cyc();
        chk("rst_mem_req",  32'(mem_req), 0);
        chk("rst_arb_err",  32'(arb_err), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall_if", 32'(stall_if), 0);
        reset = 1'b0;
        cyc();

        // single fetch, zero-wait memory
        waits = 0; rd_val = 32'h8C080004;
        cyc(); if_req = 1'b1; if_addr = 32'h00400000; #1;
        chk("f_stall_c0",  32'(stall_if), 1);
        chk("f_memreq_c0", 32'(mem_req), 0);
        cyc();
        chk("f_memreq_c1", 32'(mem_req), 1);
        chk("f_addr_c1",   mem_addr, 32'h00400000);
        chk("f_we_c1",     32'(mem_we), 0);
        chk("f_stall_c1",  32'(stall_if), 1);
        cyc();
        chk("f_ready_c2",  32'(if_ready), 1);
        chk("f_rdata_c2",  if_rdata, 32'h8C080004);
        chk("f_stall_c2",  32'(stall_if), 0);
        if_req = 1'b0;
        cyc();
        chk("f_ready_c3",  32'(if_ready), 0);
        chk("f_memreq_c3", 32'(mem_req), 0);

        // contention: store vs fetch, 2 wait states
        waits = 2; rd_val = 32'h0BADF00D;
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10010000; d_wdata = 32'h12345678;
        if_req = 1'b1; if_addr = 32'h00400004; #1;
        chk("c_stall_if_c0",  32'(stall_if), 1);
        chk("c_stall_mem_c0", 32'(stall_mem), 1);
        cyc();
        chk("c_memreq_c1", 32'(mem_req), 1);
        chk("c_we_c1",     32'(mem_we), 1);
        chk("c_addr_c1",   mem_addr, 32'h10010000);
        chk("c_wdata_c1",  mem_wdata, 32'h12345678);
        cyc();
        chk("c_dready_c2", 32'(d_ready), 0);
        cyc();
        chk("c_memreq_c3", 32'(mem_req), 1);
        chk("c_stall_if_c3", 32'(stall_if), 1);
        cyc();
        chk("c_dready_c4",   32'(d_ready), 1);
        chk("c_stall_mem_c4", 32'(stall_mem), 0);
        chk("c_stall_if_c4", 32'(stall_if), 1);
        chk("c_drdata_c4",   d_rdata, 32'h0BADF00D);
        d_req = 1'b0; d_we = 1'b0;
        cyc();
        rd_val = 32'h20090001;
        chk("c_memreq_c5",  32'(mem_req), 0);
        chk("c_stall_if_c5", 32'(stall_if), 1);
`ifdef ARB_PERF_CNT_EN
        chk("c_perf_conflict", perf_conflict, 1);
`endif
        cyc();
        chk("c_memreq_c6", 32'(mem_req), 1);
        chk("c_addr_c6",   mem_addr, 32'h00400004);
        chk("c_we_c6",     32'(mem_we), 0);
        cyc(); cyc();
        chk("c_iready_c8", 32'(if_ready), 0);
        cyc();
        chk("c_iready_c9", 32'(if_ready), 1);
        chk("c_irdata_c9", if_rdata, 32'h20090001);
        if_req = 1'b0;
        cyc();

        // flush in the 2nd BUSY_I cycle, 3 wait states
        waits = 3; rd_val = 32'hCAFE0001;
        cyc(); if_req = 1'b1; if_addr = 32'h00400008;
        cyc();
        chk("fl_memreq_c1", 32'(mem_req), 1);
        cyc(); if_flush = 1'b1; #1;
        chk("fl_ready_c2", 32'(if_ready), 0);
        cyc(); if_flush = 1'b0; if_req = 1'b0;
        cyc();
        chk("fl_memreq_c4", 32'(mem_req), 1);
        cyc();
        chk("fl_ready_c5",  32'(if_ready), 0);
        chk("fl_memreq_c5", 32'(mem_req), 0);
        chk("fl_rdata_c5",  if_rdata, 32'hCAFE0001);
        // flush in IDLE blocks the grant
        cyc(); if_req = 1'b1; if_flush = 1'b1; #1;
        chk("fl_ready_c6", 32'(if_ready), 0);
        cyc();
        chk("fl_idle_nogrant", 32'(mem_req), 0);
        if_req = 1'b0; if_flush = 1'b0;
        cyc();

        // timeout: load never answered
        waits = 1000;
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010010;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("to_memreq_c%0d", i), 32'(mem_req), 1);
        end
        cyc();
        chk("to_memreq_c5",  32'(mem_req), 0);
        chk("to_err_c5",     32'(arb_err), 1);
        chk("to_dready_c5",  32'(d_ready), 0);
        chk("to_stall_c5",   32'(stall_mem), 1);
        cyc();
        chk("to_regrant_c6", 32'(mem_req), 1);
        chk("to_err_sticky", 32'(arb_err), 1);

        // async reset between edges during BUSY_D
        #1 reset = 1'b1;
        #1;
        chk("ar_memreq",  32'(mem_req), 0);
        chk("ar_err",     32'(arb_err), 0);
        chk("ar_addr",    mem_addr, 0);
        chk("ar_irdata",  if_rdata, 0);
        d_req = 1'b0;
        cyc(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("ar_dready_%0d", i), 32'(d_ready), 0);
        end

        // back-to-back loads with a fetch queued behind
        waits = 0; rd_val = 32'h11111111;
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010020;
        if_req = 1'b1; if_addr = 32'h0040000C;
        cyc();
        chk("bb_addr_c1", mem_addr, 32'h10010020);
        cyc();
        chk("bb_dready_c2",  32'(d_ready), 1);
        chk("bb_drdata_c2",  d_rdata, 32'h11111111);
        chk("bb_stall_if_c2", 32'(stall_if), 1);
        d_addr = 32'h10010024; rd_val = 32'h22222222;
        cyc();
        chk("bb_dready_c3", 32'(d_ready), 0);
        chk("bb_memreq_c3", 32'(mem_req), 0);
        cyc();
        chk("bb_addr_c4", mem_addr, 32'h10010024);
        chk("bb_we_c4",   32'(mem_we), 0);
        cyc();
        chk("bb_dready_c5", 32'(d_ready), 1);
        chk("bb_drdata_c5", d_rdata, 32'h22222222);
        d_req = 1'b0; rd_val = 32'h33333333;
        cyc(); cyc();
        chk("bb_faddr_c7", mem_addr, 32'h0040000C);
        cyc();
        chk("bb_iready_c8", 32'(if_ready), 1);
        chk("bb_irdata_c8", if_rdata, 32'h33333333);
        if_req = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF stage (fetch, read-only) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences each access through a request/ready handshake with the memory, which may insert wait states.
- Produces stall_if / stall_mem so the hazard logic can hold PC_Write and the pipeline registers.
- MEM requests have priority because the older instruction must retire first.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max cycles in a BUSY state waiting for mem_ready before abort; must be >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch request, held high until if_ready
if_addr  input  AW  fetch address (PC_out)
if_flush  input  1  branch/jump flush; cancels the current fetch
if_ready  output  1  one-cycle pulse, if_rdata valid
if_rdata  output  DW  fetched instruction
d_req  input  1  load/store request, held until d_ready
d_we  input  1  1 = store, 0 = load
d_addr  input  AW  MEM_ALU_result
d_wdata  input  DW  MEM_Dmem_wrdata
d_ready  output  1  one-cycle pulse, load data valid / store done
d_rdata  output  DW  load data
stall_if  output  1  if_req & ~if_ready
stall_mem  output  1  d_req & ~d_ready
mem_req  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
mem_ready  input  1  memory completes the access this cycle
arb_err  output  1  sticky timeout flag

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - mem_req, mem_we, if_ready, d_ready, arb_err = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - Drop flag and timeout counter cleared.
  - Reset mid-access deasserts mem_req in the same cycle. No ready pulse is issued for the aborted access.
- States: IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I.
- IDLE:
  - d_req=1 → BUSY_D. Latch d_addr, d_wdata, d_we.
  - else if_req & ~if_flush → BUSY_I. Latch if_addr, mem_we=0.
  - else stay in IDLE.
- BUSY_x:
  - mem_req=1; mem_addr/mem_we/mem_wdata come from the latches and are stable for the whole access.
  - On mem_ready: capture mem_rdata into x_rdata → DONE_x.
  - Timeout counter increments each BUSY cycle. When it reaches TIMEOUT-1 without mem_ready: set arb_err, go to IDLE, issue no ready pulse.
- DONE_x:
  - x_ready=1 for exactly this cycle (BUSY_I drop flag clear is required for if_ready).
  - Unconditionally → IDLE; no arbitration in this cycle. The requester drops or re-presents its request at the next edge.
- Latency:
  - Minimum is 3 cycles from the request being sampled in IDLE to the ready pulse (zero-wait memory).
  - Each memory wait state adds 1 cycle.
- if_flush:
  - In IDLE: suppresses the fetch grant that cycle.
  - In BUSY_I: sets the drop flag. The memory access still completes, but DONE_I produces no if_ready.
  - In DONE_I: if_ready is suppressed.
  - The flag clears on entering IDLE.
  - if_flush has no effect on BUSY_D/DONE_D.
- Simultaneous d_req & if_req in IDLE: data wins. The fetch waits, with stall_if held high.
- d_req rising while in BUSY_I: the fetch completes first; data is granted on the next IDLE.
- stall_if / stall_mem are combinational from the inputs and registered ready flags. They read 0 whenever the corresponding req is 0.
- x_rdata holds its value until the next capture.
- A store sets d_rdata to mem_rdata as returned, which is don't-care for the pipeline.
- arb_err clears only on reset.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds three outputs: perf_if_stall[31:0], perf_mem_stall[31:0], perf_conflict[31:0].
  - perf_if_stall counts cycles with stall_if=1.
  - perf_mem_stall counts cycles with stall_mem=1.
  - perf_conflict counts IDLE cycles with d_req & if_req both high.
  - All three saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single fetch, zero-wait memory: if_req=1, if_addr=0x00400000 at cycle 0 → mem_req high at cycle 1 with mem_addr=0x00400000, mem_we=0; mem_ready at cycle 1 with mem_rdata=0x8C080004 → if_ready=1 at cycle 2 with if_rdata=0x8C080004; stall_if=1 at cycles 0–1.
- Contention: if_req and d_req (store, d_addr=0x10010000, d_wdata=0x12345678) both at cycle 0, 2 wait states → store issued first (mem_we=1), d_ready at cycle 4; fetch granted on the next IDLE; stall_if high throughout the store; perf_conflict=1 with the macro defined.
- Flush mid-fetch: fetch in BUSY_I with 3 wait states; if_flush pulse in the 2nd BUSY cycle → mem access completes, if_ready never pulses, state returns to IDLE.
- Timeout: TIMEOUT=4, load with mem_ready held 0 → mem_req deasserts after 4 BUSY cycles, arb_err=1 (sticky), d_ready stays 0, stall_mem stays 1.
- Async reset mid-access: assert reset between clock edges during BUSY_D → mem_req=0 and all outputs at reset values immediately, with no ready pulse after release.
- Back-to-back loads: d_req held across two accesses with zero-wait memory → d_ready pulses at cycles 2 and 5 (IDLE inserted); a pending if_req is still ordered behind d_req at each IDLE.
